// File: rtl/nios_upc_pio_in_irq.sv
// Avalon-MM input PIO slave with an input synchroniser, per-bit edge capture,
// an interrupt mask and a registered level IRQ toward the Nios II.
module nios_upc_pio_in_irq #(
  parameter int unsigned      WIDTH       = 8,
  parameter int unsigned      SYNC_STAGES = 2,
  parameter int unsigned      EDGE_TYPE   = 0,
  parameter logic [WIDTH-1:0] RESET_VAL   = '0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  localparam logic [1:0] ADDR_DATA = 2'd0;
  localparam logic [1:0] ADDR_MASK = 2'd2;
  localparam logic [1:0] ADDR_EDGE = 2'd3;

  // Bus protocol: a transfer is chipselect with write_n low (write) or high
  // (read); there is no wait-state, writes land on the next edge and readdata
  // always reflects the previous cycle's address, one cycle late.

  logic [WIDTH-1:0] sync_d [SYNC_STAGES];
  logic [WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [WIDTH-1:0] prev_d, prev_q;
  logic [WIDTH-1:0] irqmask_d, irqmask_q;
  logic [WIDTH-1:0] edgecap_d, edgecap_q;
  logic [31:0]      readdata_d, readdata_q;
  logic             irq_d, irq_q;

  logic [WIDTH-1:0] sync_last;
  logic [WIDTH-1:0] edge_vec;
  logic [WIDTH-1:0] clr_vec;
  logic             wr_en;
  logic             mask_we;
  logic             edge_we;
  logic             unused_wdata;

  assign sync_last    = sync_q[SYNC_STAGES-1];
  assign wr_en        = chipselect & ~write_n;
  assign mask_we      = wr_en & (address == ADDR_MASK);
  assign edge_we      = wr_en & (address == ADDR_EDGE);
  assign unused_wdata = ^writedata;

  always_comb begin
    sync_d[0] = in_port;
    for (int i = 1; i < int'(SYNC_STAGES); i++) begin
      sync_d[i] = sync_q[i-1];
    end
    prev_d = sync_last;
  end

  always_comb begin
    edge_vec = '0;
    case (EDGE_TYPE)
      0:       edge_vec = sync_last & ~prev_q;
      1:       edge_vec = ~sync_last & prev_q;
      default: edge_vec = sync_last ^ prev_q;
    endcase
  end

  // A fresh edge overrides a same-cycle clear so no event is ever lost.
  always_comb begin
    clr_vec   = edge_we ? writedata[WIDTH-1:0] : '0;
    edgecap_d = (edgecap_q & ~clr_vec) | edge_vec;
    irqmask_d = mask_we ? writedata[WIDTH-1:0] : irqmask_q;
    irq_d     = |(edgecap_q & irqmask_q);
  end

  always_comb begin
    readdata_d = '0;
    case (address)
      ADDR_DATA: readdata_d[WIDTH-1:0] = sync_last;
      ADDR_MASK: readdata_d[WIDTH-1:0] = irqmask_q;
      ADDR_EDGE: readdata_d[WIDTH-1:0] = edgecap_q;
      default:   readdata_d = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < int'(SYNC_STAGES); i++) begin
        sync_q[i] <= RESET_VAL;
      end
      prev_q     <= RESET_VAL;
      irqmask_q  <= '0;
      edgecap_q  <= '0;
      readdata_q <= '0;
      irq_q      <= 1'b0;
    end else begin
      for (int i = 0; i < int'(SYNC_STAGES); i++) begin
        sync_q[i] <= sync_d[i];
      end
      prev_q     <= prev_d;
      irqmask_q  <= irqmask_d;
      edgecap_q  <= edgecap_d;
      readdata_q <= readdata_d;
      irq_q      <= irq_d;
    end
  end

  assign readdata = readdata_q;
  assign irq      = irq_q;

endmodule

// File: tb/tb_nios_upc_pio_in_irq.sv
// Directed bench for nios_upc_pio_in_irq: four instances (rising, falling,
// any-edge, 32-bit) share one bus; each has its own in_port, readdata and irq.
module tb_nios_upc_pio_in_irq;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [7:0]  in0, in1, in2;
  logic [31:0] in3;
  logic [31:0] rd0, rd1, rd2, rd3;
  logic        irq0, irq1, irq2, irq3;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int          sel;
    logic [1:0]  addr;
    logic [31:0] exp;
    string       name;
  } vec_t;

  vec_t vecs[8];

  always #5 clk = ~clk;

  nios_upc_pio_in_irq #(.WIDTH(8), .SYNC_STAGES(2), .EDGE_TYPE(0), .RESET_VAL(8'hA5)) dut0 (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .in_port(in0), .readdata(rd0), .irq(irq0));

  nios_upc_pio_in_irq #(.WIDTH(8), .SYNC_STAGES(2), .EDGE_TYPE(1), .RESET_VAL(8'h00)) dut1 (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .in_port(in1), .readdata(rd1), .irq(irq1));

  nios_upc_pio_in_irq #(.WIDTH(8), .SYNC_STAGES(2), .EDGE_TYPE(2), .RESET_VAL(8'h00)) dut2 (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .in_port(in2), .readdata(rd2), .irq(irq2));

  nios_upc_pio_in_irq #(.WIDTH(32), .SYNC_STAGES(2), .EDGE_TYPE(0), .RESET_VAL(32'hDEADBEEF)) dut3 (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .in_port(in3), .readdata(rd3), .irq(irq3));

  function automatic logic [31:0] get_rd(input int sel);
    case (sel)
      0:       return rd0;
      1:       return rd1;
      2:       return rd2;
      default: return rd3;
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    tick();
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = '0;
  endtask

  task automatic bus_read(input int sel, input logic [1:0] a, input logic [31:0] exp, input string name);
    address    = a;
    chipselect = 1'b1;
    write_n    = 1'b1;
    tick();
    chipselect = 1'b0;
    check(name, get_rd(sel), exp);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset_n    = 1'b0;
    address    = 2'd0;
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = '0;
    in0        = 8'hA5;
    in1        = 8'hFF;
    in2        = 8'h00;
    in3        = 32'hDEADBEEF;

    vecs[0] = '{0, 2'd0, 32'h000000A5, "dut0_data"};
    vecs[1] = '{0, 2'd1, 32'h00000000, "dut0_reserved"};
    vecs[2] = '{0, 2'd2, 32'h00000000, "dut0_mask_rst"};
    vecs[3] = '{0, 2'd3, 32'h00000000, "dut0_edge_rst"};
    vecs[4] = '{1, 2'd3, 32'h00000000, "dut1_no_rise_cap"};
    vecs[5] = '{2, 2'd3, 32'h00000000, "dut2_edge_rst"};
    vecs[6] = '{3, 2'd0, 32'hDEADBEEF, "dut3_data32"};
    vecs[7] = '{3, 2'd3, 32'h00000000, "dut3_edge_rst"};

    tick(2);
    check("rst_rd0", rd0, 32'h0);
    check("rst_irq0", {31'b0, irq0}, 32'h0);
    check("rst_rd3", rd3, 32'h0);
    reset_n = 1'b1;
    tick(4);

    for (int i = 0; i < 8; i++) begin
      bus_read(vecs[i].sel, vecs[i].addr, vecs[i].exp, vecs[i].name);
    end
    check("irq0_idle", {31'b0, irq0}, 32'h0);

    // Rising-edge capture on dut0.
    in0 = 8'h00;
    tick(3);
    bus_read(0, 2'd3, 32'h00, "fall_not_captured");
    in0 = 8'h81;
    tick(3);
    bus_read(0, 2'd3, 32'h81, "rise_captured");
    in0 = 8'h00;
    tick(3);
    bus_read(0, 2'd3, 32'h81, "cap_sticky");
    check("irq_masked", {31'b0, irq0}, 32'h0);

    // IRQ flow.
    bus_write(2'd2, 32'h01);
    tick();
    check("irq_on_mask", {31'b0, irq0}, 32'h1);
    bus_write(2'd3, 32'h01);
    tick();
    check("irq_off_clear", {31'b0, irq0}, 32'h0);
    bus_read(0, 2'd3, 32'h80, "w1c_bit0");
    bus_write(2'd2, 32'h80);
    tick();
    check("irq_on_mask80", {31'b0, irq0}, 32'h1);

    // Edge on bit 2 lands in the same cycle as its clear.
    in0 = 8'h04;
    tick(2);
    bus_write(2'd3, 32'h04);
    bus_read(0, 2'd3, 32'h84, "set_wins");
    bus_write(2'd3, 32'h04);
    bus_read(0, 2'd3, 32'h80, "clear_no_edge");

    // Falling mode.
    in1 = 8'hF0;
    tick(3);
    bus_read(1, 2'd3, 32'h0F, "falling_cap");

    // Any-edge mode, bit 5 captured twice.
    in2 = 8'h20;
    tick(3);
    bus_read(2, 2'd3, 32'h20, "any_up");
    bus_write(2'd3, 32'h20);
    bus_read(2, 2'd3, 32'h00, "any_cleared");
    in2 = 8'h00;
    tick(3);
    bus_read(2, 2'd3, 32'h20, "any_down");

    // Upper writedata bits dropped on an 8-bit instance.
    bus_write(2'd2, 32'hFFFFFFFF);
    bus_read(0, 2'd2, 32'h000000FF, "mask_upper_zero");

    // 32-bit instance, then reset with captures pending.
    in3 = 32'hFFFFFFFF;
    tick(3);
    bus_read(3, 2'd3, 32'h21524110, "cap32");
    bus_read(3, 2'd0, 32'hFFFFFFFF, "data32_ff");
    check("irq3_pending", {31'b0, irq3}, 32'h1);
    in3 = 32'hDEADBEEF;
    tick(3);
    reset_n = 1'b0;
    #1;
    check("async_rd3", rd3, 32'h0);
    check("async_irq3", {31'b0, irq3}, 32'h0);
    check("async_irq0", {31'b0, irq0}, 32'h0);
    @(negedge clk);
    reset_n = 1'b1;
    tick(4);
    bus_read(3, 2'd2, 32'h0, "post_rst_mask");
    bus_read(3, 2'd3, 32'h0, "post_rst_edge");
    bus_read(3, 2'd0, 32'hDEADBEEF, "post_rst_data");
    bus_read(0, 2'd2, 32'h0, "post_rst_mask0");
    check("post_rst_irq3", {31'b0, irq3}, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/nios_upc_pio_in_irq.md
Name: nios_upc_pio_in_irq

Overview:
- Parameterised Avalon-MM input PIO slave; successor to the fixed 8-bit read-only input port.
- Adds:
  - configurable width;
  - input synchroniser;
  - per-bit edge capture, with selectable edge type;
  - interrupt mask register;
  - level IRQ output to the Nios II interrupt controller.
- Sits on the system interconnect as a 4-word slave; one instance per input bank (switches, buttons, status lines).

Parameters:
- WIDTH, 8: number of input bits, 1..32.
- SYNC_STAGES, 2: synchroniser flop depth on in_port, 2..4.
- EDGE_TYPE, 0: capture mode. 0 = rising, 1 = falling, 2 = any edge.
- RESET_VAL, 0: reset value of the synchroniser chain and the previous-sample register (WIDTH bits).

Ports:
- clk, input, 1: system clock.
- reset_n, input, 1: asynchronous active-low reset.
- address, input, 2: word address.
- chipselect, input, 1: slave select.
- write_n, input, 1: active-low write strobe.
- writedata, input, 32: write data.
- in_port, input, WIDTH: asynchronous external inputs.
- readdata, output, 32: registered read data.
- irq, output, 1: registered level interrupt, active high.

Behaviour:
- Reset is asynchronous on reset_n low, active-low; the clock is clk. On reset:
  - readdata = 0, irq = 0.
  - irqmask = 0, edgecapture = 0.
  - Synchroniser chain and previous-sample register = RESET_VAL.
- Synchroniser: in_port passes through SYNC_STAGES flops; the last stage is sync_q. A further register prev_q holds the previous sync_q.
- Edge detect, per bit:
  - rising = sync_q & ~prev_q
  - falling = ~sync_q & prev_q
  - any = sync_q ^ prev_q
  - EDGE_TYPE selects which of these is the edge vector.
- Register map (word addresses):
  - 0 DATA: read-only, value is sync_q; writes are ignored.
  - 1: reserved, reads 0, writes are ignored.
  - 2 IRQMASK: read/write, WIDTH bits. Written on chipselect & ~write_n & address==2.
  - 3 EDGECAPTURE: read/write-1-to-clear. A write with chipselect & ~write_n & address==3 clears every bit where writedata is 1.
- Edgecapture set: a bit is set in the cycle after its edge is detected and stays set until cleared.
- Simultaneous set and clear on the same bit in the same cycle: set wins, so the bit stays 1 and no edge is lost.
- Read path: readdata is registered every clk from the current address, regardless of chipselect, giving a fixed read latency of 1 cycle.
  - Bits [31:WIDTH] always read 0.
  - writedata bits [31:WIDTH] are ignored.
- Latency, in_port change to DATA: the transition appears in sync_q after SYNC_STAGES edges, and in readdata one cycle later. With the default parameters, a change sampled at edge N is visible in readdata after edge N+2, when address==0.
- Edge to edgecapture: the edgecapture bit is set on the edge after sync_q changes.
- IRQ:
  - irq is registered from |(edgecapture & irqmask), so it follows the edgecapture/irqmask state with one cycle of latency.
  - Clearing the capture bit or its mask drops irq one cycle after the register updates.
- Pulses shorter than one clk period may be missed; this is documented behaviour and is not flagged.
- Reset asserted mid-operation: all state returns to reset values immediately; captured edges and the mask are lost.
- On reset release, no spurious edge is generated, because prev_q and sync_q start equal (both RESET_VAL).
- There is no wait-state or back-pressure; writes complete in one cycle.

Test Plan:
- Reset/read: WIDTH=8, hold in_port=8'hA5, deassert reset, wait 4 cycles, read address 0 -> readdata = 32'h000000A5. Read address 1 -> 0. Read addresses 2 and 3 -> 0.
- Rising-edge capture: EDGE_TYPE=0, irqmask=0. Drive in_port 8'h00 -> 8'h81 -> edgecapture reads 8'h81. Then in_port -> 8'h00 -> edgecapture still 8'h81 and irq stays 0.
- IRQ flow: write irqmask=8'h01 -> irq=1 within 1 cycle of the mask register updating. Write 8'h01 to address 3 -> edgecapture=8'h80 and irq=0 one cycle later. Write irqmask=8'h80 -> irq=1.
- Set/clear collision: a rising edge on bit 2 is registered in the same cycle as a write of 8'h04 to address 3 -> edgecapture bit 2 remains 1.
- Modes: EDGE_TYPE=1, in_port 8'hFF -> 8'hF0 captures 8'h0F. EDGE_TYPE=2, toggle bit 5 up then down, clear between the two transitions -> the bit is captured twice.
- Width/reset: WIDTH=32, in_port=32'hDEADBEEF -> DATA reads 32'hDEADBEEF. Then assert reset_n low mid-stream with captures pending -> readdata, irq, irqmask and edgecapture all read 0 after release.
